// File: rtl/spi_word_assembler.sv
// rtl/spi_word_assembler.sv - packs synchronised SPI bytes MSB-first into words and buffers them in a show-ahead FIFO
module spi_word_assembler #(
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              clk_sys,
    input  logic                              rst,
    input  logic [7:0]                        byte_in,
    input  logic                              byte_valid,
    output logic [WORD_BYTES*8-1:0]           word_out,
    output logic                              word_valid,
    input  logic                              word_ready,
    output logic                              frame_error,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

    localparam int WW = WORD_BYTES * 8;
    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     shift_q, shift_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              frame_error_q, frame_error_d;
    logic              push_req;
    logic [WW-1:0]     push_word;

    logic [WW-1:0]     mem_q [FIFO_DEPTH];
    logic [WW-1:0]     mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     rd_next;
    logic [LW-1:0]     level_q, level_d;
    logic [WW-1:0]     word_out_q, word_out_d;
    logic              overflow_q, overflow_d;
    logic              pop;
    logic              full;
    logic              push_ok;

    // Assembler FSM: shift bytes in, push on the last byte, abandon partial words on timeout
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        count_d       = count_q;
        timer_d       = timer_q;
        frame_error_d = 1'b0;
        push_req      = 1'b0;
        push_word     = {shift_q[WW-9:0], byte_in};
        case (state_q)
            S_IDLE: begin
                if (byte_valid) begin
                    shift_d = {{(WW-8){1'b0}}, byte_in};
                    count_d = CW'(1);
                    timer_d = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // A byte arriving on the expiry cycle wins over the timeout
                if (byte_valid) begin
                    timer_d = '0;
                    shift_d = push_word;
                    if (count_q + CW'(1) == CW'(WORD_BYTES)) begin
                        push_req = 1'b1;
                        count_d  = '0;
                        state_d  = S_IDLE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_error_d = 1'b1;
                    count_d       = '0;
                    timer_d       = '0;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping: a full FIFO still accepts a push when the head pops in the same cycle
    always_comb begin
        pop        = (level_q != '0) && word_ready;
        full       = (level_q == LW'(FIFO_DEPTH));
        push_ok    = push_req && (!full || pop);
        overflow_d = overflow_q | (push_req && full && !pop);
        rd_next    = rd_ptr_q + PW'(1);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        word_out_d = word_out_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_next;
        end
        level_d = level_q + LW'(push_ok) - LW'(pop);
        // Registered head: load the pushed word into an empty FIFO, or the next entry after a pop
        if (level_q == '0) begin
            if (push_ok) begin
                word_out_d = push_word;
            end
        end else if (pop) begin
            if (level_q == LW'(1)) begin
                if (push_ok) begin
                    word_out_d = push_word;
                end
            end else begin
                word_out_d = mem_q[rd_next];
            end
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            frame_error_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            word_out_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            frame_error_q <= frame_error_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            word_out_q    <= word_out_d;
            overflow_q    <= overflow_d;
        end
    end

    // Word storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

    assign word_out    = word_out_q;
    assign word_valid  = (level_q != '0);
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_spi_word_assembler.sv
// tb/tb_spi_word_assembler.sv - directed self-checking bench for spi_word_assembler
module tb_spi_word_assembler;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        frame_error;
    logic        overflow;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    int fe_count = 0;
    int wv_count = 0;
    int snap;

    spi_word_assembler #(
        .WORD_BYTES(4),
        .TIMEOUT_CYCLES(64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_sys(clk_sys),
        .rst(rst),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .word_out(word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .frame_error(frame_error),
        .overflow(overflow),
        .fifo_level(fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    // Counts cycles with frame_error / word_valid high, sampled away from the active edge
    always @(negedge clk_sys) begin
        if (frame_error === 1'b1) fe_count++;
        if (word_valid === 1'b1) wv_count++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk_sys);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        @(negedge clk_sys);
        idle(1);
        check("rst_word_out", word_out, 32'h0);
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        rst = 1'b0;

        // Spaced bytes with consumer ready
        word_ready = 1'b1;
        snap = wv_count;
        send_byte(8'h10); idle(11);
        send_byte(8'hff); idle(11);
        send_byte(8'h00); idle(11);
        check("t1_valid_early", word_valid, 1'b0);
        send_byte(8'haa);
        check("t1_word", word_out, 32'h10ff00aa);
        check("t1_valid", word_valid, 1'b1);
        check("t1_level", fifo_level, 3'd1);
        idle(1);
        check("t1_valid_after_pop", word_valid, 1'b0);
        check("t1_level_after_pop", fifo_level, 3'd0);
        check("t1_valid_cycles", wv_count - snap, 1);
        check("t1_no_frame_error", fe_count, 0);

        // Timeout discards a partial word
        send_byte(8'hba);
        send_byte(8'hdc);
        send_byte(8'haf);
        idle(63);
        check("t2_fe_before", frame_error, 1'b0);
        idle(1);
        check("t2_fe_pulse", frame_error, 1'b1);
        idle(1);
        check("t2_fe_after", frame_error, 1'b0);
        check("t2_fe_count", fe_count, 1);
        check("t2_no_word", word_valid, 1'b0);
        send_word(32'hbadcafee);
        check("t2_word", word_out, 32'hbadcafee);
        check("t2_valid", word_valid, 1'b1);
        idle(1);

        // Overflow with consumer stalled, then drain
        word_ready = 1'b0;
        send_word(32'h00000001);
        send_word(32'h00000002);
        send_word(32'h00000003);
        send_word(32'h00000004);
        check("t3_level_full", fifo_level, 3'd4);
        check("t3_ovf_before", overflow, 1'b0);
        send_word(32'h00000005);
        check("t3_level_still_full", fifo_level, 3'd4);
        check("t3_overflow", overflow, 1'b1);
        word_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t3_drain_word", word_out, 32'(i));
            check("t3_drain_valid", word_valid, 1'b1);
            @(negedge clk_sys);
        end
        word_ready = 1'b0;
        check("t3_empty", word_valid, 1'b0);
        check("t3_level_empty", fifo_level, 3'd0);
        check("t3_overflow_sticky", overflow, 1'b1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        check("t4_ovf_cleared", overflow, 1'b0);
        send_word(32'h000000a0);
        send_word(32'h000000a1);
        send_word(32'h000000a2);
        send_word(32'h000000a3);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        byte_in    = 8'h78;
        byte_valid = 1'b1;
        word_ready = 1'b1;
        @(negedge clk_sys);
        byte_valid = 1'b0;
        word_ready = 1'b0;
        check("t4_level", fifo_level, 3'd4);
        check("t4_overflow", overflow, 1'b0);
        check("t4_head", word_out, 32'h000000a1);
        word_ready = 1'b1;
        check("t4_d1", word_out, 32'h000000a1); @(negedge clk_sys);
        check("t4_d2", word_out, 32'h000000a2); @(negedge clk_sys);
        check("t4_d3", word_out, 32'h000000a3); @(negedge clk_sys);
        check("t4_d4", word_out, 32'h12345678); @(negedge clk_sys);
        check("t4_empty", word_valid, 1'b0);

        // Reset mid-frame with a buffered word; bytes during reset are ignored
        word_ready = 1'b0;
        send_word(32'h55667788);
        send_byte(8'h99);
        send_byte(8'haa);
        rst        = 1'b1;
        byte_in    = 8'hde;
        byte_valid = 1'b1;
        @(negedge clk_sys);
        rst        = 1'b0;
        byte_valid = 1'b0;
        check("t5_word_out", word_out, 32'h0);
        check("t5_valid", word_valid, 1'b0);
        check("t5_level", fifo_level, 3'd0);
        check("t5_overflow", overflow, 1'b0);
        check("t5_frame_error", frame_error, 1'b0);
        word_ready = 1'b1;
        send_word(32'h11223344);
        check("t5_word", word_out, 32'h11223344);
        check("t5_valid_after", word_valid, 1'b1);
        idle(1);

        // Bytes landing exactly on the expiry cycle keep the frame alive
        snap = fe_count;
        send_byte(8'hc0);
        send_byte(8'hff);
        idle(63);
        send_byte(8'hee);
        idle(63);
        send_byte(8'h01);
        check("t6_word", word_out, 32'hc0ffee01);
        check("t6_valid", word_valid, 1'b1);
        idle(2);
        check("t6_no_frame_error", fe_count - snap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
